// File: rtl/pa_cpu.sv
// Shared CPU package: interrupt count, service-state encoding and vector encoding.
package pa_cpu;
    localparam int NBR_IRQS  = 8;
    localparam int VEC_SHIFT = 1;

    typedef enum logic {ST_IDLE, ST_VECTORED} irq_state_t;

    // The sequencer dispatches on even vectors, so the index is scaled by 2.
    function automatic logic [NBR_IRQS-1:0] enc_vector(input logic [2:0] idx);
        return NBR_IRQS'(idx) << VEC_SHIFT;
    endfunction
endpackage

// File: rtl/irq_controller_if.sv
// Bus between the microcode sequencer (master) and the interrupt controller (slave).
interface irq_controller_if;
    import pa_cpu::*;

    logic [NBR_IRQS-1:0] irq_in;
    logic [7:0]          z_bus;
    logic                ctrl_irq_masks_wrt;
    logic                ctrl_int_vector_wrt;
    logic                ctrl_int_ack;
    logic                ctrl_clear_all_ints;
    logic                int_pending;
    logic [7:0]          int_vector;
    logic [NBR_IRQS-1:0] irq_masks;
    logic [NBR_IRQS-1:0] irq_status;

    modport master (
        output irq_in, z_bus, ctrl_irq_masks_wrt, ctrl_int_vector_wrt,
               ctrl_int_ack, ctrl_clear_all_ints,
        input  int_pending, int_vector, irq_masks, irq_status
    );

    modport slave (
        input  irq_in, z_bus, ctrl_irq_masks_wrt, ctrl_int_vector_wrt,
               ctrl_int_ack, ctrl_clear_all_ints,
        output int_pending, int_vector, irq_masks, irq_status
    );
endinterface

// File: rtl/irq_controller_edge_detect.sv
// Per-line conditioning and rising-edge detection for the interrupt request lines.
// Macro IRQ_CTRL_SYNC_EN selects a two-flop synchronizer; otherwise one register stage.
module irq_edge_detect
    import pa_cpu::*;
(
    input  logic                clk,
    input  logic                _rst,
    input  logic [NBR_IRQS-1:0] irq_in,
    output logic [NBR_IRQS-1:0] rise
);
    logic [NBR_IRQS-1:0] s2, s3;

`ifdef IRQ_CTRL_SYNC_EN
    logic [NBR_IRQS-1:0] s1;

    always_ff @(posedge clk) begin
        if (!_rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= irq_in;
            s2 <= s1;
            s3 <= s2;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!_rst) begin
            s2 <= '0;
            s3 <= '0;
        end else begin
            s2 <= irq_in;
            s3 <= s2;
        end
    end
`endif

    // Zeroed flops mean a line held high through reset yields one edge after release.
    assign rise = s2 & ~s3;
endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge-latched pending bits, software mask, fixed priority
// (bit 0 highest) and a two-state vector/ack service handshake with the sequencer.
module irq_controller
    import pa_cpu::*;
(
    input  logic             clk,
    input  logic             _rst,
    irq_controller_if.slave  bus
);
    logic [NBR_IRQS-1:0] rise, pending, masks, active;
    logic [7:0]          vector;
    logic [2:0]          win_idx, svc_idx;
    logic                int_pend;
    irq_state_t          state;

    irq_edge_detect u_edge (
        .clk    (clk),
        ._rst   (_rst),
        .irq_in (bus.irq_in),
        .rise   (rise)
    );

    assign active = pending & masks;

    always_comb begin
        win_idx = '0;
        for (int i = NBR_IRQS - 1; i >= 0; i--)
            if (active[i]) win_idx = 3'(i);
    end

    wire vec_take = !bus.ctrl_int_vector_wrt && (|active);
    wire ack_take = bus.ctrl_int_ack && (state == ST_VECTORED);

    always_ff @(posedge clk) begin
        if (!_rst) begin
            pending  <= '0;
            masks    <= '0;
            vector   <= '0;
            int_pend <= 1'b0;
            state    <= ST_IDLE;
            svc_idx  <= '0;
        end else begin
            int_pend <= |active;
            if (!bus.ctrl_irq_masks_wrt) masks <= bus.z_bus;

            // Clear-all beats a new edge, which beats the ack of the serviced bit.
            for (int i = 0; i < NBR_IRQS; i++) begin
                if (bus.ctrl_clear_all_ints)            pending[i] <= 1'b0;
                else if (rise[i])                       pending[i] <= 1'b1;
                else if (ack_take && svc_idx == 3'(i))  pending[i] <= 1'b0;
            end

            if (vec_take) begin
                vector  <= enc_vector(win_idx);
                svc_idx <= win_idx;
            end

            if (bus.ctrl_clear_all_ints) state <= ST_IDLE;
            else if (vec_take)           state <= ST_VECTORED;
            else if (ack_take)           state <= ST_IDLE;
        end
    end

    assign bus.int_pending = int_pend;
    assign bus.int_vector  = vector;
    assign bus.irq_masks   = masks;
    assign bus.irq_status  = pending;
endmodule

// File: tb/tb_irq_controller.sv
// Directed test of irq_controller (default build: single-register input stage).
module tb_irq_controller;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    irq_controller_if bus ();

    irq_controller dut (
        .clk  (clk),
        ._rst (rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Drive and sample 1ns after each rising edge.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.irq_in              = '0;
        bus.z_bus               = '0;
        bus.ctrl_irq_masks_wrt  = 1'b1;
        bus.ctrl_int_vector_wrt = 1'b1;
        bus.ctrl_int_ack        = 1'b0;
        bus.ctrl_clear_all_ints = 1'b0;
    endtask

    task automatic write_mask(input logic [7:0] m);
        bus.z_bus = m; bus.ctrl_irq_masks_wrt = 1'b0;
        tick();
        bus.ctrl_irq_masks_wrt = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick(2);
        total++;
        if ({bus.int_pending, bus.int_vector, bus.irq_masks, bus.irq_status} !== 25'd0) begin
            bad++;
            $display("FAIL reset_outputs: got pend=%b vec=%h mask=%h st=%h, want all 0",
                     bus.int_pending, bus.int_vector, bus.irq_masks, bus.irq_status);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        write_mask(8'hFF);
        total++;
        if (bus.irq_masks !== 8'hFF) begin
            bad++; $display("FAIL mask_write: got %h want ff", bus.irq_masks);
        end
        bus.irq_in = 8'h08;
        tick(2);
        bus.irq_in = 8'h00;
        total++;
        if (bus.irq_status !== 8'h08 || bus.int_pending !== 1'b0) begin
            bad++; $display("FAIL basic_capture: got st=%h pend=%b want 08/0", bus.irq_status, bus.int_pending);
        end
        tick();
        total++;
        if (bus.int_pending !== 1'b1) begin
            bad++; $display("FAIL basic_int_pending: got %b want 1", bus.int_pending);
        end
        bus.ctrl_int_vector_wrt = 1'b0;
        tick();
        bus.ctrl_int_vector_wrt = 1'b1;
        total++;
        if (bus.int_vector !== 8'h06) begin
            bad++; $display("FAIL basic_vector: got %h want 06", bus.int_vector);
        end
        bus.ctrl_int_ack = 1'b1;
        tick();
        bus.ctrl_int_ack = 1'b0;
        total++;
        if (bus.irq_status !== 8'h00 || bus.int_pending !== 1'b1) begin
            bad++; $display("FAIL basic_ack: got st=%h pend=%b want 00/1", bus.irq_status, bus.int_pending);
        end
        tick();
        total++;
        if (bus.int_pending !== 1'b0) begin
            bad++; $display("FAIL basic_pend_fall: got %b want 0", bus.int_pending);
        end
    endtask

    task automatic test_masking();
        write_mask(8'h00);
        bus.irq_in = 8'h20;
        tick(2);
        bus.irq_in = 8'h00;
        tick();
        total++;
        if (bus.irq_status !== 8'h20 || bus.int_pending !== 1'b0) begin
            bad++; $display("FAIL masked_hold: got st=%h pend=%b want 20/0", bus.irq_status, bus.int_pending);
        end
        write_mask(8'h20);
        total++;
        if (bus.irq_masks !== 8'h20 || bus.int_pending !== 1'b0) begin
            bad++; $display("FAIL unmask_edge: got mask=%h pend=%b want 20/0", bus.irq_masks, bus.int_pending);
        end
        tick();
        total++;
        if (bus.int_pending !== 1'b1) begin
            bad++; $display("FAIL unmask_pend: got %b want 1", bus.int_pending);
        end
        bus.ctrl_clear_all_ints = 1'b1;
        tick();
        bus.ctrl_clear_all_ints = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        write_mask(8'hFF);
        bus.irq_in = 8'h44;
        tick(2);
        bus.irq_in = 8'h00;
        total++;
        if (bus.irq_status !== 8'h44) begin
            bad++; $display("FAIL prio_capture: got %h want 44", bus.irq_status);
        end
        bus.ctrl_int_vector_wrt = 1'b0; tick(); bus.ctrl_int_vector_wrt = 1'b1;
        total++;
        if (bus.int_vector !== 8'h04) begin
            bad++; $display("FAIL prio_vec1: got %h want 04", bus.int_vector);
        end
        bus.ctrl_int_ack = 1'b1; tick(); bus.ctrl_int_ack = 1'b0;
        total++;
        if (bus.irq_status !== 8'h40) begin
            bad++; $display("FAIL prio_ack1: got %h want 40", bus.irq_status);
        end
        bus.ctrl_int_vector_wrt = 1'b0; tick(); bus.ctrl_int_vector_wrt = 1'b1;
        total++;
        if (bus.int_vector !== 8'h0C) begin
            bad++; $display("FAIL prio_vec2: got %h want 0c", bus.int_vector);
        end
        bus.ctrl_int_ack = 1'b1; tick(); bus.ctrl_int_ack = 1'b0;
        tick();
        total++;
        if (bus.irq_status !== 8'h00 || bus.int_pending !== 1'b0) begin
            bad++; $display("FAIL prio_drain: got st=%h pend=%b want 00/0", bus.irq_status, bus.int_pending);
        end
    endtask

    task automatic test_edge_vs_ack();
        bus.irq_in = 8'h02;
        tick(2);
        bus.irq_in = 8'h00;
        bus.ctrl_int_vector_wrt = 1'b0; tick(); bus.ctrl_int_vector_wrt = 1'b1;
        total++;
        if (bus.int_vector !== 8'h02) begin
            bad++; $display("FAIL eva_vector: got %h want 02", bus.int_vector);
        end
        // New edge reaches the detector on the same edge the ack is sampled.
        bus.irq_in = 8'h02;
        tick();
        bus.ctrl_int_ack = 1'b1;
        tick();
        bus.ctrl_int_ack = 1'b0;
        tick();
        total++;
        if (bus.irq_status !== 8'h02 || bus.int_pending !== 1'b1) begin
            bad++; $display("FAIL edge_beats_ack: got st=%h pend=%b want 02/1", bus.irq_status, bus.int_pending);
        end
        bus.irq_in = 8'h00;
        bus.ctrl_clear_all_ints = 1'b1; tick(); bus.ctrl_clear_all_ints = 1'b0;
        tick();
    endtask

    task automatic test_clear_all();
        bus.irq_in = 8'hFF;
        tick(2);
        bus.irq_in = 8'h00;
        bus.ctrl_int_vector_wrt = 1'b0; tick(); bus.ctrl_int_vector_wrt = 1'b1;
        total++;
        if (bus.irq_status !== 8'hFF || bus.int_vector !== 8'h00) begin
            bad++; $display("FAIL clr_setup: got st=%h vec=%h want ff/00", bus.irq_status, bus.int_vector);
        end
        bus.ctrl_clear_all_ints = 1'b1; tick(); bus.ctrl_clear_all_ints = 1'b0;
        total++;
        if (bus.irq_status !== 8'h00) begin
            bad++; $display("FAIL clr_status: got %h want 00", bus.irq_status);
        end
        // svc_idx is still 0; if clear left the FSM vectored, this ack would drop bit 0.
        bus.irq_in = 8'h01;
        tick(2);
        bus.irq_in = 8'h00;
        bus.ctrl_int_ack = 1'b1; tick(); bus.ctrl_int_ack = 1'b0;
        total++;
        if (bus.irq_status !== 8'h01) begin
            bad++; $display("FAIL clr_ack_idle: got %h want 01", bus.irq_status);
        end
        bus.ctrl_clear_all_ints = 1'b1; tick(); bus.ctrl_clear_all_ints = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_service();
        bus.irq_in = 8'h01;
        tick(2);
        bus.ctrl_int_vector_wrt = 1'b0; tick(); bus.ctrl_int_vector_wrt = 1'b1;
        rst_n = 1'b0;
        bus.ctrl_int_ack = 1'b1;
        tick();
        bus.ctrl_int_ack = 1'b0;
        total++;
        if ({bus.int_pending, bus.int_vector, bus.irq_masks, bus.irq_status} !== 25'd0) begin
            bad++;
            $display("FAIL rst_mid: got pend=%b vec=%h mask=%h st=%h, want all 0",
                     bus.int_pending, bus.int_vector, bus.irq_masks, bus.irq_status);
        end
        rst_n = 1'b1;
        tick(2);
        total++;
        if (bus.irq_status !== 8'h01) begin
            bad++; $display("FAIL rst_one_edge: got %h want 01", bus.irq_status);
        end
        write_mask(8'hFF);
        bus.ctrl_int_vector_wrt = 1'b0; tick(); bus.ctrl_int_vector_wrt = 1'b1;
        bus.ctrl_int_ack = 1'b1; tick(); bus.ctrl_int_ack = 1'b0;
        tick(3);
        total++;
        if (bus.irq_status !== 8'h00 || bus.int_pending !== 1'b0) begin
            bad++; $display("FAIL rst_no_reedge: got st=%h pend=%b want 00/0", bus.irq_status, bus.int_pending);
        end
        bus.irq_in = 8'h00;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_masking();
        test_priority();
        test_edge_vs_ack();
        test_clear_all();
        test_reset_mid_service();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
# irq_controller

Collects the eight external interrupt request lines, latches rising edges into a pending register, and applies the software-written mask. It drives `int_pending` and the interrupt vector consumed by the microcode sequencer. It sits directly upstream of the sequencer and is controlled by the sequencer's `ctrl_irq_masks_wrt`, `ctrl_int_vector_wrt`, `ctrl_int_ack` and `ctrl_clear_all_ints` outputs. The vector is captured when the trap microcode writes it, and the serviced request is retired on acknowledge.

## Interface
- NBR_IRQS, 8, number of request lines; fixed at 8 because the mask is loaded from the 8-bit `z_bus`.
- clk  input  1  system clock; all state changes on posedge.
- _rst  input  1  reset, synchronous, active-low.
- irq_in  input  8  external requests, asynchronous, active high; bit 0 has the highest priority.
- z_bus  input  8  mask write data.
- ctrl_irq_masks_wrt  input  1  active low; load `irq_masks` from `z_bus`.
- ctrl_int_vector_wrt  input  1  active low; latch the vector of the winning request.
- ctrl_int_ack  input  1  active high; retire the in-service request.
- ctrl_clear_all_ints  input  1  active high; clear all pending bits.
- int_pending  output  1  registered; at least one pending request is unmasked.
- int_vector  output  8  latched vector, equal to winning index × 2.
- irq_masks  output  8  mask register; 1 = enabled.
- irq_status  output  8  raw pending register, masked bits included.

## Operation
- Edge capture: a bit is set in `pending[i]` when the conditioned line `s2[i]` is 1 and its one-cycle-delayed copy `s3[i]` is 0. Level-high holding does not re-set the bit.
- Masking:
  - `active = pending & irq_masks`.
  - A masked request stays pending and becomes active as soon as it is unmasked.
- Priority: `win_idx` is the lowest set bit of `active`.
- `int_pending` is registered: `int_pending <= |active`, evaluated with the current-cycle `pending` and `irq_masks`.
- Service state machine, `ST_IDLE` / `ST_VECTORED`:
  - `ctrl_int_vector_wrt == 0` with `|active`: `int_vector <= {4'b0, win_idx, 1'b0}`, `svc_idx <= win_idx`, go to `ST_VECTORED`.
  - `ctrl_int_vector_wrt == 0` with no active request: `int_vector` is unchanged and the state is unchanged.
  - `ctrl_int_vector_wrt == 0` in `ST_VECTORED`: re-latch as above.
  - `ctrl_int_ack` in `ST_VECTORED`: clear `pending[svc_idx]`, go to `ST_IDLE`.
  - `ctrl_int_ack` in `ST_IDLE`: no effect.
- Mask write: `irq_masks <= z_bus` when `ctrl_irq_masks_wrt == 0`.
- Per-bit precedence, highest first:
  - `ctrl_clear_all_ints` clears `pending`. It also returns the state to `ST_IDLE`. Edges detected in the same cycle are lost.
  - A new edge detected on bit `svc_idx` in the ack cycle sets the bit. The new event wins over the ack.
  - Ack clears the bit.
- Vector write and ack in the same cycle: the ack retires the old `svc_idx`. The new latch takes effect and the state ends in `ST_VECTORED`.
- Reset (`_rst == 0` at posedge) sets all of the following, overriding every control, including mid-service:
  - `pending = 0`, `irq_masks = 0x00`, `int_vector = 0x00`, `int_pending = 0`;
  - state `ST_IDLE`, `svc_idx = 0`;
  - synchronizer and delay flops `= 0`. A line held high through reset therefore produces one edge after release.

## Timing
- With `IRQ_CTRL_SYNC_EN`, for `irq_in` rising before posedge E0:
  - `s1 = 1` after E0, `s2 = 1` after E1;
  - `pending` set at E2;
  - `int_pending` high after E3, provided the bit is unmasked.
- Without `IRQ_CTRL_SYNC_EN`:
  - `s2 = 1` after E0;
  - `pending` set at E1;
  - `int_pending` high after E2.
- Vector write at E: `int_vector` is valid after E.
- Ack at E: the pending bit clears at E, and `int_pending` falls after E+1 if nothing else is active.
- Mask write at E: `irq_masks` updates at E, and `int_pending` reflects the new mask after E+1.
- A minimum `irq_in` high pulse of 2 clocks is guaranteed to be captured with the synchronizer; 1 clock is sufficient without it.

## Configuration
- `IRQ_CTRL_SYNC_EN`
  - Defined: `irq_in` passes through a two-flop synchronizer (`s1`, `s2`) before edge detection.
  - Undefined: `irq_in` is registered once directly into `s2`, for synchronous sources in simulation. Latency is reduced by one cycle and all other behaviour is identical.

## Structure
- Shared package `pa_cpu`:
  - `NBR_IRQS`;
  - `typedef enum logic {ST_IDLE, ST_VECTORED} irq_state_t`;
  - the vector-encoding constant (shift by 1).
- Sub-module `irq_edge_detect`: a per-vector synchronizer plus edge detector producing `rise[7:0]`, with the macro handled inside it. Priority, pending, mask and the FSM stay in `irq_controller`.

## Test plan
- Reset, then write mask 0xFF. Pulse `irq_in[3]` for 2 clocks → `irq_status = 0x08` at E2, `int_pending = 1` after E3. Vector write → `int_vector = 0x06`. Ack → `irq_status = 0x00`, `int_pending = 0` one cycle later.
- Mask 0x00, raise `irq_in[5]` → `irq_status = 0x20`, `int_pending` stays 0. Write mask 0x20 → `int_pending = 1` the next cycle.
- Pulse lines 2 and 6 together with mask 0xFF → vector write gives `0x04`. Ack → `irq_status = 0x40`. Second vector write gives `0x0C`.
- Vectored on line 1, then a new `irq_in[1]` edge is detected in the ack cycle → `irq_status[1]` remains 1 and `int_pending` stays 1.
- `irq_status = 0xFF` in `ST_VECTORED`, assert `ctrl_clear_all_ints` → `irq_status = 0x00`, state `ST_IDLE`. A following ack has no effect.
- Assert `_rst` low while `ST_VECTORED` with mask 0xFF and `irq_in[0]` held high → all outputs 0 after the posedge. After release, exactly one edge is captured on line 0.
